// File: rtl/debouncer_array_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debouncer_array_pkg
// Description : Sizing helpers shared by the debouncer channel and array.
// Revision    : 1.0 - initial release
// ============================================================================
package debouncer_array_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debouncer_channel.sv
`default_nettype none
// ============================================================================
// Module      : debouncer_channel
// Description : Single-bit debouncer: 2-flop synchroniser, stability counter,
//               debounced level, validity flag and rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module debouncer_channel
    import debouncer_array_pkg::*;
#(
    parameter int high_count = 1,
    parameter int low_count  = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic in,
    output logic out,
    output logic valid,
    output logic rise,
    output logic fall
);

    localparam int c_cnt_w = clog2(max(high_count, low_count) + 1);
    localparam logic [c_cnt_w-1:0] c_high_thr = c_cnt_w'(high_count);
    localparam logic [c_cnt_w-1:0] c_low_thr  = c_cnt_w'(low_count);

    logic               r_sync0;
    logic               r_sync;
    logic               r_last;
    logic [c_cnt_w-1:0] r_count;
    logic               r_out;
    logic               r_valid;
    logic               r_rise;
    logic               r_fall;

    logic               w_change;
    logic [c_cnt_w-1:0] w_thr;
    logic               w_stable;

    // Threshold follows the current synchronised level every cycle.
    assign w_change = (r_sync != r_last);
    assign w_thr    = r_sync ? c_high_thr : c_low_thr;
    assign w_stable = !w_change && (r_count == w_thr);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync0 <= 1'b0;
            r_sync  <= 1'b0;
            r_last  <= 1'b0;
            r_count <= '0;
            r_out   <= 1'b0;
            r_valid <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync0 <= in;
            r_sync  <= r_sync0;
            r_last  <= r_sync;

            if (w_change) begin
                r_count <= '0;
            end else if (enable && (r_count < w_thr)) begin
                r_count <= r_count + 1'b1;
            end

            r_valid <= w_stable;

            if (w_stable && (r_out != r_sync)) begin
                r_out  <= r_sync;
                r_rise <= r_sync;
                r_fall <= ~r_sync;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end
        end
    end

    assign out   = r_out;
    assign valid = r_valid;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/debouncer_array.sv
`default_nettype none
// ============================================================================
// Module      : debouncer_array
// Description : Array of independent debouncer channels sharing one enable tick.
// Revision    : 1.0 - initial release
// ============================================================================
module debouncer_array
    import debouncer_array_pkg::*;
#(
    parameter int width      = 1,
    parameter int high_count = 1,
    parameter int low_count  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [width-1:0] in,
    output logic [width-1:0] out,
    output logic [width-1:0] valid,
    output logic [width-1:0] rise,
    output logic [width-1:0] fall
);

    if ((width < 1) || (high_count < 1) || (low_count < 1)) begin : g_bad_params
        $error("debouncer_array: width, high_count and low_count must all be >= 1");
    end

    for (genvar i = 0; i < width; i++) begin : g_channel
        debouncer_channel #(
            .high_count (high_count),
            .low_count  (low_count)
        ) u_channel (
            .clock  (clock),
            .reset  (reset),
            .enable (enable),
            .in     (in[i]),
            .out    (out[i]),
            .valid  (valid[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

endmodule
`default_nettype wire
